// File: rtl/dcache_mem_arbiter_if.sv
// Bundle of the store-queue, load-FU and memory-bus signals seen by the
// dcache memory arbiter. The arbiter uses the master modport, since it
// drives the memory bus. The requesters and the memory model use the slave
// modport.
//
// Handshake: a requester raises its enable and holds the address, data and id
// steady until the matching grant pulse (dcachectrl_st_request_sent or
// ld_request_sent[i]) is high in the same cycle. A grant is only issued when
// memory answers the command with a nonzero mem2proc_response. That response
// value is the tag, and the same tag later comes back on mem2proc_tag with the
// load data.
interface dcache_mem_arbiter_if #(
  parameter int LD_ENTRIES = 4,
  parameter int ID_W       = 5,
  parameter int SC_W       = 2
);
  // store queue side
  logic                  sq_mem_en;
  logic [63:0]           sq_mem_addr;
  logic [63:0]           sq_mem_data;
  logic                  dcachectrl_st_request_sent;
  // load FU side
  logic [1:0]            ld_req_en;
  logic [1:0][63:0]      ld_req_addr;
  logic [1:0][ID_W-1:0]  ld_req_id;
  logic [1:0]            ld_request_sent;
  // memory bus
  logic [1:0]            proc2mem_command;
  logic [63:0]           proc2mem_addr;
  logic [63:0]           proc2mem_data;
  logic [3:0]            mem2proc_response;
  logic [63:0]           mem2proc_data;
  logic [3:0]            mem2proc_tag;
  // load completion
  logic                  ld_done_valid;
  logic [ID_W-1:0]       ld_done_id;
  logic [63:0]           ld_done_data;
  logic                  ld_table_full;
  // debug view of registered state
  logic [SC_W-1:0]       dbg_starve_cnt;
  logic [LD_ENTRIES-1:0] dbg_slot_valid;

  modport master (
    input  sq_mem_en, sq_mem_addr, sq_mem_data,
    input  ld_req_en, ld_req_addr, ld_req_id,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output dcachectrl_st_request_sent, ld_request_sent,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output ld_done_valid, ld_done_id, ld_done_data, ld_table_full,
    output dbg_starve_cnt, dbg_slot_valid
  );

  modport slave (
    output sq_mem_en, sq_mem_addr, sq_mem_data,
    output ld_req_en, ld_req_addr, ld_req_id,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  dcachectrl_st_request_sent, ld_request_sent,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  ld_done_valid, ld_done_id, ld_done_data, ld_table_full,
    input  dbg_starve_cnt, dbg_slot_valid
  );
endinterface

// File: rtl/dcache_mem_arbiter.sv
// Arbiter for the single processor-memory port. It chooses between the
// store-queue writeback and two load FUs, and issues one command per cycle.
// Accepted loads are kept in a small table indexed by memory tag, so the
// returning data can be paired with the requester id. A starvation counter
// forces a waiting store ahead of loads once it has been refused often enough.
module dcache_mem_arbiter #(
  parameter int LD_ENTRIES   = 4,
  parameter int ID_W         = 5,
  parameter int STARVE_LIMIT = 3
) (
  input logic                  clk,
  input logic                  reset,
  dcache_mem_arbiter_if.master bus
);
  localparam int              SC_W      = $clog2(STARVE_LIMIT + 1);
  localparam int              IDX_W     = (LD_ENTRIES > 1) ? $clog2(LD_ENTRIES) : 1;
  localparam logic [SC_W-1:0] SC_MAX    = SC_W'(STARVE_LIMIT);
  localparam logic [1:0]      CMD_NONE  = 2'd0;
  localparam logic [1:0]      CMD_LOAD  = 2'd1;
  localparam logic [1:0]      CMD_STORE = 2'd2;

  // registered state
  logic [LD_ENTRIES-1:0] r_valid;
  logic [3:0]            r_tag [LD_ENTRIES];
  logic [ID_W-1:0]       r_id  [LD_ENTRIES];
  logic [SC_W-1:0]       r_starve;
  logic                  r_done_valid;
  logic [ID_W-1:0]       r_done_id;
  logic [63:0]           r_done_data;

  // combinational
  logic                  w_full;
  logic                  w_load_ok;
  logic                  w_ld_elig;
  logic                  w_sel_st;
  logic                  w_sel_ld0;
  logic                  w_sel_ld1;
  logic [1:0]            w_cmd;
  logic [63:0]           w_addr;
  logic [63:0]           w_data;
  logic                  w_accept;
  logic                  w_st_grant;
  logic [1:0]            w_ld_grant;
  logic                  w_alloc;
  logic [ID_W-1:0]       w_alloc_id;
  logic [IDX_W-1:0]      w_alloc_idx;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_hit_idx;
  logic                  w_unused;

  // The bus is doubleword aligned, so the low address bits are never looked at.
  assign w_unused = ^{bus.sq_mem_addr[2:0], bus.ld_req_addr[0][2:0], bus.ld_req_addr[1][2:0]};

  // Requester selection: a store wins when it is starved or no load can go.
  always_comb begin
    w_full    = &r_valid;
    w_load_ok = ~w_full;
    w_ld_elig = (|bus.ld_req_en) & w_load_ok;
    w_sel_st  = bus.sq_mem_en & ((r_starve == SC_MAX) | ~w_ld_elig);
    w_sel_ld0 = ~w_sel_st & bus.ld_req_en[0] & w_load_ok;
    w_sel_ld1 = ~w_sel_st & ~bus.ld_req_en[0] & bus.ld_req_en[1] & w_load_ok;
  end

  // Bus command drive and same-cycle grants on acceptance.
  always_comb begin
    w_cmd  = CMD_NONE;
    w_addr = 64'd0;
    w_data = 64'd0;
    if (w_sel_st) begin
      w_cmd  = CMD_STORE;
      w_addr = {bus.sq_mem_addr[63:3], 3'b000};
      w_data = bus.sq_mem_data;
    end else if (w_sel_ld0) begin
      w_cmd  = CMD_LOAD;
      w_addr = {bus.ld_req_addr[0][63:3], 3'b000};
    end else if (w_sel_ld1) begin
      w_cmd  = CMD_LOAD;
      w_addr = {bus.ld_req_addr[1][63:3], 3'b000};
    end
    w_accept   = (w_cmd != CMD_NONE) && (bus.mem2proc_response != 4'd0);
    w_st_grant = w_sel_st & w_accept;
    w_ld_grant = {w_sel_ld1 & w_accept, w_sel_ld0 & w_accept};
    w_alloc    = |w_ld_grant;
    w_alloc_id = w_ld_grant[0] ? bus.ld_req_id[0] : bus.ld_req_id[1];
  end

  // Table lookup: the returning tag's slot, and the lowest free slot for allocation.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_idx   = '0;
    w_alloc_idx = '0;
    for (int i = 0; i < LD_ENTRIES; i++) begin
      if (r_valid[i] && (bus.mem2proc_tag != 4'd0) && (r_tag[i] == bus.mem2proc_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
    for (int i = LD_ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_alloc_idx = IDX_W'(i);
    end
  end

  // Starvation counter: counts refused cycles of a waiting store, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!bus.sq_mem_en || w_st_grant) begin
      r_starve <= '0;
    end else if (r_starve != SC_MAX) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Outstanding-load table. A returning slot is valid, so it never equals the
  // free slot picked in the same cycle, and both updates can apply together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < LD_ENTRIES; i++) begin
        r_tag[i] <= '0;
        r_id[i]  <= '0;
      end
    end else begin
      if (w_hit) r_valid[w_hit_idx] <= 1'b0;
      if (w_alloc) begin
        r_valid[w_alloc_idx] <= 1'b1;
        r_tag[w_alloc_idx]   <= bus.mem2proc_response;
        r_id[w_alloc_idx]    <= w_alloc_id;
      end
    end
  end

  // Registered load completion, one cycle after the matching tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done_valid <= 1'b0;
      r_done_id    <= '0;
      r_done_data  <= 64'd0;
    end else begin
      r_done_valid <= w_hit;
      if (w_hit) begin
        r_done_id   <= r_id[w_hit_idx];
        r_done_data <= bus.mem2proc_data;
      end
    end
  end

  assign bus.proc2mem_command           = w_cmd;
  assign bus.proc2mem_addr              = w_addr;
  assign bus.proc2mem_data              = w_data;
  assign bus.dcachectrl_st_request_sent = w_st_grant;
  assign bus.ld_request_sent            = w_ld_grant;
  assign bus.ld_table_full              = w_full;
  assign bus.ld_done_valid              = r_done_valid;
  assign bus.ld_done_id                 = r_done_id;
  assign bus.ld_done_data               = r_done_data;
  assign bus.dbg_starve_cnt             = r_starve;
  assign bus.dbg_slot_valid             = r_valid;
endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Directed bench for dcache_mem_arbiter. Inputs change 1ns after a rising
// edge. Combinational outputs are checked 2ns later, and registered outputs
// are checked 1ns after the following edge.
module tb_dcache_mem_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  dcache_mem_arbiter_if #(.LD_ENTRIES(4), .ID_W(5), .SC_W(2)) bus_if ();

  dcache_mem_arbiter #(.LD_ENTRIES(4), .ID_W(5), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    bus_if.sq_mem_en         = 1'b0;
    bus_if.sq_mem_addr       = 64'd0;
    bus_if.sq_mem_data       = 64'd0;
    bus_if.ld_req_en         = 2'b00;
    bus_if.ld_req_addr       = '0;
    bus_if.ld_req_id         = '0;
    bus_if.mem2proc_response = 4'd0;
    bus_if.mem2proc_data     = 64'd0;
    bus_if.mem2proc_tag      = 4'd0;
  endtask

  // Return a tag with data and check the completion on the following edge.
  task automatic return_tag(input string tag, input logic [3:0] t, input logic [63:0] d,
                            input logic [4:0] exp_id);
    bus_if.mem2proc_tag  = t;
    bus_if.mem2proc_data = d;
    tick;
    chk({tag, "_valid"}, 64'(bus_if.ld_done_valid), 64'd1);
    chk({tag, "_id"},    64'(bus_if.ld_done_id),    64'(exp_id));
    chk({tag, "_data"},  bus_if.ld_done_data,       d);
    bus_if.mem2proc_tag  = 4'd0;
    bus_if.mem2proc_data = 64'd0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    reset = 1'b1;
    tick;
    tick;
    chk("rst_full",   64'(bus_if.ld_table_full),    64'd0);
    chk("rst_done",   64'(bus_if.ld_done_valid),    64'd0);
    chk("rst_cmd",    64'(bus_if.proc2mem_command), 64'd0);
    chk("rst_starve", 64'(bus_if.dbg_starve_cnt),   64'd0);
    chk("rst_slots",  64'(bus_if.dbg_slot_valid),   64'd0);
    reset = 1'b0;
    tick;

    // Starvation: loads on port 0 win three times, then the store is forced.
    bus_if.sq_mem_en      = 1'b1;
    bus_if.sq_mem_addr    = 64'h1007;
    bus_if.sq_mem_data    = 64'h55;
    bus_if.ld_req_en      = 2'b01;
    bus_if.ld_req_addr[0] = 64'h2003;
    bus_if.ld_req_id[0]   = 5'd9;
    for (int k = 0; k < 3; k++) begin
      bus_if.mem2proc_response = 4'(k + 1);
      settle;
      chk("stv_cmd_ld",   64'(bus_if.proc2mem_command),           64'd1);
      chk("stv_ld_sent",  64'(bus_if.ld_request_sent),            64'd1);
      chk("stv_st_sent",  64'(bus_if.dcachectrl_st_request_sent), 64'd0);
      chk("stv_ld_addr",  bus_if.proc2mem_addr,                   64'h2000);
      chk("stv_ld_data",  bus_if.proc2mem_data,                   64'd0);
      tick;
      chk("stv_cnt",      64'(bus_if.dbg_starve_cnt),             64'(k + 1));
    end
    bus_if.mem2proc_response = 4'd4;
    settle;
    chk("stv_cmd_st",  64'(bus_if.proc2mem_command),           64'd2);
    chk("stv_st_go",   64'(bus_if.dcachectrl_st_request_sent), 64'd1);
    chk("stv_ld_hold", 64'(bus_if.ld_request_sent),            64'd0);
    chk("stv_st_addr", bus_if.proc2mem_addr,                   64'h1000);
    chk("stv_st_data", bus_if.proc2mem_data,                   64'h55);
    tick;
    chk("stv_cnt_clr", 64'(bus_if.dbg_starve_cnt), 64'd0);
    chk("stv_slots",   64'(bus_if.dbg_slot_valid), 64'b0111);
    idle_inputs();

    // Return tag 3, then reset while the completion is showing.
    return_tag("ret3", 4'd3, 64'hAA, 5'd9);
    chk("ret3_slots", 64'(bus_if.dbg_slot_valid), 64'b0011);
    reset = 1'b1;
    #1;
    chk("mid_rst_done",  64'(bus_if.ld_done_valid),  64'd0);
    chk("mid_rst_full",  64'(bus_if.ld_table_full),  64'd0);
    chk("mid_rst_slots", 64'(bus_if.dbg_slot_valid), 64'd0);
    tick;
    reset = 1'b0;
    bus_if.mem2proc_tag  = 4'd2;
    bus_if.mem2proc_data = 64'hBAD;
    tick;
    chk("stale_tag", 64'(bus_if.ld_done_valid), 64'd0);
    idle_inputs();

    // Both ports request: port 0 first, then port 1.
    bus_if.ld_req_en         = 2'b11;
    bus_if.ld_req_addr[0]    = 64'h3000;
    bus_if.ld_req_addr[1]    = 64'h400F;
    bus_if.ld_req_id[0]      = 5'd3;
    bus_if.ld_req_id[1]      = 5'd17;
    bus_if.mem2proc_response = 4'd5;
    settle;
    chk("dual_sent0", 64'(bus_if.ld_request_sent), 64'b01);
    chk("dual_addr0", bus_if.proc2mem_addr,        64'h3000);
    tick;
    chk("dual_slot0", 64'(bus_if.dbg_slot_valid), 64'b0001);
    bus_if.ld_req_en         = 2'b10;
    bus_if.mem2proc_response = 4'd6;
    settle;
    chk("dual_sent1", 64'(bus_if.ld_request_sent), 64'b10);
    chk("dual_addr1", bus_if.proc2mem_addr,        64'h4008);
    tick;
    chk("dual_slot1", 64'(bus_if.dbg_slot_valid), 64'b0011);
    bus_if.ld_req_en         = 2'b00;
    bus_if.mem2proc_response = 4'd0;
    return_tag("ret5", 4'd5, 64'hDEAD, 5'd3);
    chk("ret5_slots", 64'(bus_if.dbg_slot_valid), 64'b0010);
    tick;
    chk("done_clear", 64'(bus_if.ld_done_valid), 64'd0);
    return_tag("ret6", 4'd6, 64'hBEEF, 5'd17);
    chk("ret6_slots", 64'(bus_if.dbg_slot_valid), 64'd0);
    idle_inputs();

    // Fill all four slots with tags 1-4.
    bus_if.ld_req_en      = 2'b01;
    bus_if.ld_req_addr[0] = 64'h6000;
    for (int k = 0; k < 4; k++) begin
      bus_if.ld_req_id[0]      = 5'(20 + k);
      bus_if.mem2proc_response = 4'(k + 1);
      tick;
    end
    chk("fill_slots", 64'(bus_if.dbg_slot_valid), 64'b1111);
    chk("fill_full",  64'(bus_if.ld_table_full),  64'd1);
    bus_if.mem2proc_response = 4'd5;
    settle;
    chk("full_no_ld",  64'(bus_if.ld_request_sent),  64'd0);
    chk("full_no_cmd", 64'(bus_if.proc2mem_command), 64'd0);
    bus_if.sq_mem_en   = 1'b1;
    bus_if.sq_mem_addr = 64'h5010;
    bus_if.sq_mem_data = 64'h77;
    #1;
    chk("full_st_cmd",  64'(bus_if.proc2mem_command),           64'd2);
    chk("full_st_sent", 64'(bus_if.dcachectrl_st_request_sent), 64'd1);
    chk("full_st_cnt",  64'(bus_if.dbg_starve_cnt),             64'd0);
    tick;
    bus_if.sq_mem_en         = 1'b0;
    bus_if.mem2proc_response = 4'd0;
    bus_if.mem2proc_tag      = 4'd2;
    bus_if.mem2proc_data     = 64'hB2;
    settle;
    chk("full_ret_nogrant", 64'(bus_if.ld_request_sent), 64'd0);
    tick;
    chk("ret2_valid", 64'(bus_if.ld_done_valid),  64'd1);
    chk("ret2_id",    64'(bus_if.ld_done_id),     64'd21);
    chk("ret2_data",  bus_if.ld_done_data,        64'hB2);
    chk("ret2_full",  64'(bus_if.ld_table_full),  64'd0);
    chk("ret2_slots", 64'(bus_if.dbg_slot_valid), 64'b1101);
    bus_if.mem2proc_tag      = 4'd0;
    bus_if.ld_req_id[0]      = 5'd30;
    bus_if.mem2proc_response = 4'd9;
    settle;
    chk("reuse_sent", 64'(bus_if.ld_request_sent), 64'b01);
    tick;
    chk("reuse_slots", 64'(bus_if.dbg_slot_valid), 64'b1111);
    bus_if.ld_req_en         = 2'b00;
    bus_if.mem2proc_response = 4'd0;
    return_tag("ret9", 4'd9, 64'h99, 5'd30);
    chk("ret9_slots", 64'(bus_if.dbg_slot_valid), 64'b1101);
    return_tag("ret1", 4'd1, 64'h11, 5'd20);
    return_tag("ret3b", 4'd3, 64'h33, 5'd22);
    return_tag("ret4", 4'd4, 64'h44, 5'd23);
    chk("drain_slots", 64'(bus_if.dbg_slot_valid), 64'd0);
    idle_inputs();

    // Refused store: no grant, counter climbs and saturates, then accepted.
    bus_if.sq_mem_en   = 1'b1;
    bus_if.sq_mem_addr = 64'h7008;
    bus_if.sq_mem_data = 64'h88;
    settle;
    chk("ref_cmd",  64'(bus_if.proc2mem_command),           64'd2);
    chk("ref_sent", 64'(bus_if.dcachectrl_st_request_sent), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("ref_cnt", 64'(bus_if.dbg_starve_cnt), 64'((k > 3) ? 3 : k));
    end
    bus_if.mem2proc_response = 4'd1;
    settle;
    chk("ref_accept", 64'(bus_if.dcachectrl_st_request_sent), 64'd1);
    tick;
    chk("ref_cnt_clr", 64'(bus_if.dbg_starve_cnt), 64'd0);
    idle_inputs();

    // Same-cycle return of tag 7 and a new load accepted with tag 7.
    bus_if.ld_req_en         = 2'b01;
    bus_if.ld_req_addr[0]    = 64'h8000;
    bus_if.ld_req_id[0]      = 5'd11;
    bus_if.mem2proc_response = 4'd7;
    tick;
    chk("t7_slot0", 64'(bus_if.dbg_slot_valid), 64'b0001);
    bus_if.ld_req_id[0]  = 5'd12;
    bus_if.mem2proc_tag  = 4'd7;
    bus_if.mem2proc_data = 64'h77AA;
    settle;
    chk("t7_sent", 64'(bus_if.ld_request_sent), 64'b01);
    tick;
    chk("t7_valid", 64'(bus_if.ld_done_valid),  64'd1);
    chk("t7_id",    64'(bus_if.ld_done_id),     64'd11);
    chk("t7_data",  bus_if.ld_done_data,        64'h77AA);
    chk("t7_slots", 64'(bus_if.dbg_slot_valid), 64'b0010);
    idle_inputs();
    tick;
    chk("t7_hold", 64'(bus_if.dbg_slot_valid), 64'b0010);
    return_tag("t7_new", 4'd7, 64'h1234, 5'd12);
    chk("t7_empty", 64'(bus_if.dbg_slot_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
